// File: rtl/stream_capture_buffer.sv
// stream_capture_buffer: arms on a rising edge of enable, captures up to
// capture_len 64-bit samples from an Avalon-ST source into a dual-port
// memory, then serves them to a processor as 32-bit halves, low half first.
// The capture length is held in 16 bits, so DEPTH must not exceed 32768.
module stream_capture_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [15:0]        capture_len,
  input  logic               data_valid,
  input  logic signed [63:0] data,
  input  logic               rd_req,
  output logic [31:0]        rd_data,
  output logic               rd_data_valid,
  output logic               ready,
  output logic               fifo_lleno,
  output logic               overflow,
  output logic [15:0]        sample_count
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FULL
  } state_t;

  localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic          enable_q;
  logic [15:0]   len_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          half_sel;
  logic [63:0]   mem [DEPTH];

  logic [15:0]   eff_len;
  logic          arm;
  logic          abort;
  logic          wr_en;
  logic          rd_en;
  logic          last_write;
  logic          last_read;

  // A length of zero, or one larger than the memory, means "fill the memory".
  assign eff_len = (capture_len == 16'd0 || capture_len > DEPTH_LEN) ? DEPTH_LEN : capture_len;

  // Only a genuine low-to-high transition arms; a level left high after
  // readout does not restart a capture.
  assign arm        = (state == IDLE) && enable && !enable_q;
  assign abort      = (state == CAPTURE) && !enable;
  assign wr_en      = (state == CAPTURE) && enable && data_valid;
  assign rd_en      = (state == FULL) && rd_req;
  assign last_write = wr_en && (sample_count + 16'd1 == len_q);
  assign last_read  = rd_en && half_sel && (16'(rd_ptr) == len_q - 16'd1);

  assign ready      = (state == FULL);
  assign fifo_lleno = (state == FULL);

  // Previous-cycle copy of enable for edge detection; it tracks the pin even
  // during reset so an enable held high through reset is not seen as an edge.
  always_ff @(posedge clock) begin
    // NOTE: registers are always assigned with <= so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    enable_q <= enable;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives
    // state_next, so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (arm) state_next = CAPTURE;
      CAPTURE: begin
        if (abort)           state_next = IDLE;
        else if (last_write) state_next = FULL;
      end
      FULL:    if (last_read) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture bookkeeping: length, pointers, sample count and overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      half_sel     <= 1'b0;
      sample_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (arm) begin
        len_q        <= eff_len;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        half_sel     <= 1'b0;
        sample_count <= '0;
        overflow     <= 1'b0;
      end
      if (abort) sample_count <= '0;
      if (wr_en) begin
        wr_ptr       <= wr_ptr + AW'(1);
        sample_count <= sample_count + 16'd1;
      end
      if (state == FULL && data_valid) overflow <= 1'b1;
      if (rd_en) begin
        half_sel <= ~half_sel;
        if (half_sel) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Capture memory write port.
  always_ff @(posedge clock) begin
    // NOTE: the memory array has no reset; a stale word is never read because
    // readout is bounded by the length latched at arm time.
    if (wr_en) mem[wr_ptr] <= data;
  end

  // Registered read port: one half-word per accepted request, one-cycle latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en) rd_data <= half_sel ? mem[rd_ptr][63:32] : mem[rd_ptr][31:0];
    end
  end

endmodule

// File: tb/tb_stream_capture_buffer.sv
// Self-checking bench for stream_capture_buffer: directed scenarios plus a
// random soak, compared against a queue-based behavioural model; read data
// is scored by an independent monitor.
module tb_stream_capture_buffer;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [15:0]        capture_len;
  logic               data_valid;
  logic signed [63:0] data;
  logic               rd_req;
  logic [31:0]        rd_data;
  logic               rd_data_valid;
  logic               ready;
  logic               fifo_lleno;
  logic               overflow;
  logic [15:0]        sample_count;

  stream_capture_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .capture_len   (capture_len),
    .data_valid    (data_valid),
    .data          (data),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .ready         (ready),
    .fifo_lleno    (fifo_lleno),
    .overflow      (overflow),
    .sample_count  (sample_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Expected read half-words, in issue order.
  logic [31:0] exp_q[$];

  // Behavioural model: captured samples kept as a queue, readout tracked as a
  // count of half-words already delivered.
  typedef enum {PH_IDLE, PH_CAPTURING, PH_HOLDING} phase_t;
  phase_t      m_phase   = PH_IDLE;
  logic [63:0] m_cap[$];
  int          m_len     = 0;
  int          m_halves  = 0;
  int          m_count   = 0;
  bit          m_ovf     = 1'b0;
  bit          m_prev_en = 1'b0;
  bit          m_rdv     = 1'b0;
  logic [31:0] m_rd_hold = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the effect of one clock edge with the given inputs.
  task automatic model_edge(input bit rst, input bit en, input bit v,
                            input logic [63:0] d, input bit rq);
    logic [63:0] word;
    m_rdv = 1'b0;
    if (rst) begin
      m_phase   = PH_IDLE;
      m_count   = 0;
      m_ovf     = 1'b0;
      m_rd_hold = '0;
    end else begin
      case (m_phase)
        PH_IDLE: if (en && !m_prev_en) begin
          m_len    = (capture_len == 0 || int'(capture_len) > DEPTH) ? DEPTH : int'(capture_len);
          m_cap.delete();
          m_halves = 0;
          m_count  = 0;
          m_ovf    = 1'b0;
          m_phase  = PH_CAPTURING;
        end
        PH_CAPTURING: begin
          if (!en) begin
            m_phase = PH_IDLE;
            m_count = 0;
          end else if (v) begin
            m_cap.push_back(d);
            m_count++;
            if (m_count == m_len) m_phase = PH_HOLDING;
          end
        end
        PH_HOLDING: begin
          if (v) m_ovf = 1'b1;
          if (rq) begin
            word      = m_cap[m_halves / 2];
            m_rd_hold = (m_halves % 2 == 1) ? word[63:32] : word[31:0];
            exp_q.push_back(m_rd_hold);
            m_rdv     = 1'b1;
            m_halves++;
            if (m_halves == 2 * m_len) m_phase = PH_IDLE;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
    m_prev_en = en;
  endtask

  // Drive one cycle, advance the model, then compare status outputs #1 after the edge.
  task automatic step(input bit rst, input bit en, input bit v,
                      input logic [63:0] d, input bit rq);
    reset      = rst;
    enable     = en;
    data_valid = v;
    data       = d;
    rd_req     = rq;
    model_edge(rst, en, v, d, rq);
    @(posedge clock);
    #1;
    check("ready",         ready,         (m_phase == PH_HOLDING));
    check("fifo_lleno",    fifo_lleno,    (m_phase == PH_HOLDING));
    check("overflow",      overflow,      m_ovf);
    check("sample_count",  sample_count,  m_count);
    check("rd_data_valid", rd_data_valid, m_rdv);
    check("rd_data",       rd_data,       m_rd_hold);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic arm(input logic [15:0] len);
    capture_len = len;
    step(0, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
  endtask

  // Offer n valid samples with random gaps, optionally with stray read strobes.
  task automatic feed(input int n, input bit stray_reads);
    int sent = 0;
    while (sent < n) begin
      bit v = ($urandom % 4) != 0;
      step(0, 1, v, rand64(), stray_reads ? 1'($urandom % 2) : 1'b0);
      if (v) sent++;
    end
  endtask

  // Issue n read strobes with random gaps; noisy also wiggles enable and data_valid.
  task automatic reads(input int n, input bit noisy);
    int sent = 0;
    while (sent < n) begin
      bit rq = ($urandom % 3) != 0;
      step(0, noisy ? 1'($urandom % 2) : 1'b1, noisy ? 1'($urandom % 2) : 1'b0, rand64(), rq);
      if (rq) sent++;
    end
  endtask

  // Scoreboard monitor: every presented read half-word must match the oldest expectation.
  always @(negedge clock) begin
    if (rd_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: rd_data_valid=1 rd_data=%0h with no read pending at %0t", rd_data, $time);
      end else begin
        check("rd_data_sb", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; data_valid = 1'b0; data = '0; rd_req = 1'b0;
    capture_len = 16'd4;

    // Reset with random activity on every input.
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom % 2), 1'($urandom % 2), rand64(), 1'($urandom % 2));

    // Basic capture: 4 of 6 samples kept, 5th sets overflow, 8 half-word reads.
    arm(16'd4);
    for (int n = 0; n < 6; n++) step(0, 1, 1, 64'h0000_0001_0000_0002 + 64'(n), 0);
    for (int n = 0; n < 8; n++) step(0, 1, 0, '0, 1);
    // Enable still high after readout: no re-arm even with samples offered.
    for (int n = 0; n < 4; n++) step(0, 1, 1, rand64(), 0);

    // Full depth, first with length 0 then with an oversize length.
    arm(16'd0);
    feed(300, 0);
    reads(512, 1);
    arm(16'd300);
    feed(300, 0);
    reads(512, 0);

    // Abort after 3 of 8 samples, then a clean capture from address 0.
    arm(16'd8);
    feed(3, 0);
    step(0, 0, 1, rand64(), 0);
    step(0, 0, 0, '0, 0);
    arm(16'd8);
    feed(8, 0);
    reads(16, 0);

    // Ignored inputs: reads during capture, enable toggling while holding.
    arm(16'd4);
    feed(4, 1);
    step(0, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 1, 1, rand64(), 0);
    reads(8, 0);

    // Reset in the middle of readout, then a fresh 2-sample capture.
    arm(16'd8);
    feed(8, 0);
    reads(3, 0);
    step(1, 1, 1, rand64(), 1);
    arm(16'd2);
    feed(2, 0);
    reads(4, 0);

    // Random soak with occasional aborts and resets.
    for (int i = 0; i < 3000; i++) begin
      int sel = $urandom % 8;
      capture_len = (sel == 0) ? 16'd0 : (sel == 1) ? 16'd300 : 16'($urandom_range(1, 12));
      step(($urandom % 500) == 0, ($urandom % 40) != 0, 1'($urandom % 2), rand64(), 1'($urandom % 2));
    end

    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    @(negedge clock);
    #1;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_capture_buffer.md
STREAM_CAPTURE_BUFFER -- requirements
Module: stream_capture_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256: number of 64-bit words in the capture memory (power of two).
REQ-002 The block SHALL have parameter AW, default 8: address width, log2(DEPTH).
REQ-003 The block SHALL have port clock  in  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enable  in  1  arm level; a rising edge starts a capture.
REQ-006 The block SHALL have port capture_len  in  16  number of samples to capture; 0 or >DEPTH means DEPTH.
REQ-007 The block SHALL have port data_valid  in  1  Avalon-ST input valid (upstream filter chain output).
REQ-008 The block SHALL have port data  in  64  signed Avalon-ST input sample.
REQ-009 The block SHALL have port rd_req  in  1  processor read strobe, one 32-bit half per pulse.
REQ-010 The block SHALL have port rd_data  out  32  read half-word, registered.
REQ-011 The block SHALL have port rd_data_valid  out  1  one-cycle qualifier for rd_data.
REQ-012 The block SHALL have port ready  out  1  capture complete and data readable.
REQ-013 The block SHALL have port fifo_lleno  out  1  capture memory holds the requested length.
REQ-014 The block SHALL have port overflow  out  1  sticky: sample offered while full.
REQ-015 The block SHALL have port sample_count  out  16  samples written in the current capture.

Function
REQ-016 The block SHALL implement states IDLE, CAPTURE, FULL.
REQ-017 In IDLE, on an enable rising edge (enable=1 and previous-cycle enable=0), the block SHALL latch the effective length L, clear wr_ptr, rd_ptr, half-select, sample_count and overflow, and enter CAPTURE the next cycle.
REQ-018 In CAPTURE, each cycle with data_valid=1 SHALL write data to memory[wr_ptr] and increment wr_ptr and sample_count; data_valid=0 cycles SHALL write nothing.
REQ-019 The write that makes sample_count equal L SHALL move the state to FULL, and ready and fifo_lleno SHALL read 1 on the following cycle.
REQ-020 enable=0 during CAPTURE SHALL abort: return to IDLE next cycle, sample_count cleared to 0, ready and fifo_lleno remaining 0.
REQ-021 In FULL, data_valid=1 SHALL NOT write memory and SHALL set overflow to 1 until the next arm or reset.
REQ-022 In FULL, each rd_req pulse SHALL return memory[rd_ptr][31:0] when half-select=0 and memory[rd_ptr][63:32] when half-select=1, with rd_data_valid=1 exactly one cycle after rd_req.
REQ-023 half-select SHALL toggle on each accepted rd_req, and rd_ptr SHALL increment after each high half.
REQ-024 Acceptance of the high half of word L-1 SHALL return the state to IDLE, clearing ready and fifo_lleno on the next cycle; that final rd_data_valid SHALL still be delivered.
REQ-025 In IDLE or CAPTURE, rd_req SHALL be ignored: rd_data_valid stays 0 and rd_data holds its value.
REQ-026 An enable rising edge in FULL SHALL be ignored, so data is never lost before readout.
REQ-027 If enable is still 1 on return to IDLE, the block SHALL NOT re-arm until enable goes low and then rises again.
REQ-028 Simultaneous data_valid and rd_req in FULL SHALL produce both responses independently: overflow set and a read returned.
REQ-029 The memory SHALL be single-clock dual-port with one write and one read port, and read latency SHALL be 1 cycle.

Reset
REQ-030 While reset=1, the block SHALL force state IDLE, all pointers, half-select and sample_count to 0, and rd_data, rd_data_valid, ready, fifo_lleno and overflow to 0.
REQ-031 Reset asserted mid-CAPTURE or mid-readout SHALL take effect on the next edge and discard the capture; memory contents need not be cleared.

Verification
REQ-032 Reset test: assert reset 3 cycles with random inputs -> all outputs 0 and state IDLE.
REQ-033 Basic capture test: capture_len=4, enable rise, 6 valid samples 0x0000000100000002 +n -> fifo_lleno and ready=1 after the 4th sample, overflow=1 after the 5th; 8 rd_req give 00000002,00000001,00000003,00000001,... then ready=0.
REQ-034 Full-depth test: capture_len=0, then 300 → 256 samples captured, sample_count=256, and 512 reads reproduce the input in order.
REQ-035 Abort test: capture_len=8, 3 samples, enable low -> IDLE, sample_count=0, fifo_lleno=0; a new rising edge restarts from address 0.
REQ-036 Ignored-input test: rd_req during CAPTURE -> no rd_data_valid; enable toggle during FULL -> contents unchanged.
REQ-037 Reset-during-readout test: reset after 3 of 8 reads -> all outputs 0; a fresh capture of 2 samples reads back correctly from word 0, low half first.
